// File: rtl/mole_pixel_gen.sv
// Whack-A-Mole pixel colour stage: 3x3 hole/mole grid, frame-latched mole mask, hit-flash timer.
// Latency: 2 clk from h_count/v_count/syncs to rgb/hsync_out/vsync_out; frame_start 1 clk after origin.
// Backpressure: none; free-running pixel stream, one pixel accepted and produced every clock.
module mole_pixel_gen #(
  parameter int H_START      = 144,
  parameter int H_END        = 784,
  parameter int V_START      = 35,
  parameter int V_END        = 515,
  parameter int GRID_X0      = 80,
  parameter int GRID_Y0      = 60,
  parameter int CELL_W       = 160,
  parameter int CELL_H       = 120,
  parameter int MOLE_INSET   = 20,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_count,
  input  logic [10:0] v_count,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [8:0]  mole_up,
  input  logic        hit_strobe,
  input  logic [3:0]  hit_cell,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  localparam logic [10:0] LP_H_START = 11'(H_START);
  localparam logic [10:0] LP_H_END   = 11'(H_END);
  localparam logic [10:0] LP_V_START = 11'(V_START);
  localparam logic [10:0] LP_V_END   = 11'(V_END);

  // Column / row boundaries in active-area coordinates
  localparam logic [10:0] LP_GX0 = 11'(GRID_X0);
  localparam logic [10:0] LP_GX1 = 11'(GRID_X0 + CELL_W);
  localparam logic [10:0] LP_GX2 = 11'(GRID_X0 + 2 * CELL_W);
  localparam logic [10:0] LP_GX3 = 11'(GRID_X0 + 3 * CELL_W);
  localparam logic [10:0] LP_GY0 = 11'(GRID_Y0);
  localparam logic [10:0] LP_GY1 = 11'(GRID_Y0 + CELL_H);
  localparam logic [10:0] LP_GY2 = 11'(GRID_Y0 + 2 * CELL_H);
  localparam logic [10:0] LP_GY3 = 11'(GRID_Y0 + 3 * CELL_H);

  // Mole square bounds inside a cell (lower inclusive, upper exclusive)
  localparam logic [10:0] LP_MX_LO = 11'(MOLE_INSET);
  localparam logic [10:0] LP_MX_HI = 11'(CELL_W - MOLE_INSET);
  localparam logic [10:0] LP_MY_LO = 11'(MOLE_INSET);
  localparam logic [10:0] LP_MY_HI = 11'(CELL_H - MOLE_INSET);

  localparam logic [3:0] LP_FLASH = 4'(FLASH_FRAMES);

  localparam logic [1:0] LP_OUTSIDE = 2'd3;

  localparam logic [7:0] C_BLACK = 8'h00;
  localparam logic [7:0] C_GRASS = 8'b000_101_00;
  localparam logic [7:0] C_RED   = 8'b111_000_00;
  localparam logic [7:0] C_MOLE  = 8'b110_100_01;
  localparam logic [7:0] C_HOLE  = 8'b011_001_00;

  // Stage-1 decode wires
  logic        w_active;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [1:0]  w_col;
  logic [1:0]  w_row;
  logic [10:0] w_lx;
  logic [10:0] w_ly;
  logic        w_origin;

  // Stage-1 registers
  logic        r_act;
  logic [1:0]  r_col;
  logic [1:0]  r_row;
  logic [10:0] r_lx;
  logic [10:0] r_ly;
  logic        r_hs1;
  logic        r_vs1;

  // Stage-2 output registers
  logic [7:0]  r_rgb;
  logic        r_hs2;
  logic        r_vs2;

  // Frame and game state
  logic        r_origin_d;
  logic        r_frame_start;
  logic [8:0]  r_mask;
  logic [3:0]  r_flash_cnt;
  logic [3:0]  r_flash_cell;

  // Stage-2 colour wires
  logic        w_in_grid;
  logic [3:0]  w_cell;
  logic [15:0] w_mask16;
  logic        w_in_mole;
  logic [7:0]  w_rgb;

  assign w_active = (h_count >= LP_H_START) && (h_count < LP_H_END) &&
                    (v_count >= LP_V_START) && (v_count < LP_V_END);
  assign w_x      = h_count - LP_H_START;
  assign w_y      = v_count - LP_V_START;
  assign w_origin = (h_count == 11'd0) && (v_count == 11'd0);

  // Column decode by range compare; local x is the offset from the column's left edge
  always_comb begin
    w_col = LP_OUTSIDE;
    w_lx  = 11'd0;
    if (w_x < LP_GX0) begin
      w_col = LP_OUTSIDE;
    end else if (w_x < LP_GX1) begin
      w_col = 2'd0;
      w_lx  = w_x - LP_GX0;
    end else if (w_x < LP_GX2) begin
      w_col = 2'd1;
      w_lx  = w_x - LP_GX1;
    end else if (w_x < LP_GX3) begin
      w_col = 2'd2;
      w_lx  = w_x - LP_GX2;
    end
  end

  // Row decode, same scheme as columns
  always_comb begin
    w_row = LP_OUTSIDE;
    w_ly  = 11'd0;
    if (w_y < LP_GY0) begin
      w_row = LP_OUTSIDE;
    end else if (w_y < LP_GY1) begin
      w_row = 2'd0;
      w_ly  = w_y - LP_GY0;
    end else if (w_y < LP_GY2) begin
      w_row = 2'd1;
      w_ly  = w_y - LP_GY1;
    end else if (w_y < LP_GY3) begin
      w_row = 2'd2;
      w_ly  = w_y - LP_GY2;
    end
  end

  // Stage 1: register the geometric decode and the first sync delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act <= 1'b0;
      r_col <= 2'd0;
      r_row <= 2'd0;
      r_lx  <= 11'd0;
      r_ly  <= 11'd0;
      r_hs1 <= 1'b0;
      r_vs1 <= 1'b0;
    end else begin
      r_act <= w_active;
      r_col <= w_col;
      r_row <= w_row;
      r_lx  <= w_lx;
      r_ly  <= w_ly;
      r_hs1 <= hsync_in;
      r_vs1 <= vsync_in;
    end
  end

  assign w_in_grid = (r_col != LP_OUTSIDE) && (r_row != LP_OUTSIDE);
  assign w_cell    = ({2'b00, r_row} * 4'd3) + {2'b00, r_col};
  assign w_mask16  = {7'd0, r_mask};
  assign w_in_mole = (r_lx >= LP_MX_LO) && (r_lx < LP_MX_HI) &&
                     (r_ly >= LP_MY_LO) && (r_ly < LP_MY_HI);

  // Colour select in priority order: blank, grass, hit flash, mole, hole
  always_comb begin
    w_rgb = C_BLACK;
    if (!r_act) begin
      w_rgb = C_BLACK;
    end else if (!w_in_grid) begin
      w_rgb = C_GRASS;
    end else if (w_in_mole && (r_flash_cnt != 4'd0) && (r_flash_cell == w_cell)) begin
      w_rgb = C_RED;
    end else if (w_in_mole && w_mask16[w_cell]) begin
      w_rgb = C_MOLE;
    end else begin
      w_rgb = C_HOLE;
    end
  end

  // Stage 2: register colour and the second sync delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb <= 8'd0;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
    end
  end

  // Frame-start pulse on entry to the origin; holding at origin does not retrigger
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_origin_d    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_origin_d    <= w_origin;
      r_frame_start <= w_origin && !r_origin_d;
    end
  end

  // Mole mask is sampled only at frame start so a frame never shows a half-updated mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= 9'd0;
    end else if (r_frame_start) begin
      r_mask <= mole_up;
    end
  end

  // Hit flash: a valid hit (re)loads the timer and wins over the per-frame decrement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flash_cnt  <= 4'd0;
      r_flash_cell <= 4'd0;
    end else if (hit_strobe && (hit_cell <= 4'd8)) begin
      r_flash_cnt  <= LP_FLASH;
      r_flash_cell <= hit_cell;
    end else if (r_frame_start && (r_flash_cnt != 4'd0)) begin
      r_flash_cnt  <= r_flash_cnt - 4'd1;
    end
  end

  assign rgb         = r_rgb;
  assign hsync_out   = r_hs2;
  assign vsync_out   = r_vs2;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_mole_pixel_gen.sv
// Directed bench for mole_pixel_gen: scoreboard of expected pixels/syncs popped 2 clk after drive.
// Latency: expects rgb/syncs 2 clk after inputs, frame_start 1 clk after origin entry.
// Backpressure: none; one stimulus step per clock.
module tb_mole_pixel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        hsync_in;
  logic        vsync_in;
  logic [8:0]  mole_up;
  logic        hit_strobe;
  logic [3:0]  hit_cell;
  logic [7:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_start;

  localparam logic [7:0] C_GRASS = 8'b000_101_00;
  localparam logic [7:0] C_RED   = 8'b111_000_00;
  localparam logic [7:0] C_MOLE  = 8'b110_100_01;
  localparam logic [7:0] C_HOLE  = 8'b011_001_00;

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       prev_org = 1'b0;
  logic [8:0] tb_mask = 9'd0;
  int         tb_fcnt = 0;
  int         tb_fcell = 0;

  always #20 clk = ~clk;

  mole_pixel_gen dut (
    .clk         (clk),
    .rst         (rst),
    .h_count     (h_count),
    .v_count     (v_count),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .mole_up     (mole_up),
    .hit_strobe  (hit_strobe),
    .hit_cell    (hit_cell),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .frame_start (frame_start)
  );

  // Reference colour from screen geometry, written with divide/modulo
  function automatic logic [7:0] exp_colour(input int h, input int v, input logic [8:0] mask,
                                            input int fcnt, input int fcell);
    int x, y, col, row, lx, ly, c;
    logic inm;
    if (h < 144 || h >= 784 || v < 35 || v >= 515) return 8'h00;
    x = h - 144;
    y = v - 35;
    if (x < 80 || x >= 560 || y < 60 || y >= 420) return C_GRASS;
    col = (x - 80) / 160;
    row = (y - 60) / 120;
    lx  = (x - 80) % 160;
    ly  = (y - 60) % 120;
    c   = row * 3 + col;
    inm = (lx >= 20) && (lx < 140) && (ly >= 20) && (ly < 100);
    if (inm && fcnt != 0 && fcell == c) return C_RED;
    if (inm && mask[c]) return C_MOLE;
    return C_HOLE;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; pops the entry pushed two steps earlier
  task automatic step(input int h, input int v, input logic hs, input logic vs,
                      input logic hit, input logic [3:0] hc);
    exp_t e;
    logic efs;
    h_count    = 11'(h);
    v_count    = 11'(v);
    hsync_in   = hs;
    vsync_in   = vs;
    hit_strobe = hit;
    hit_cell   = hc;
    e.rgb = exp_colour(h, v, tb_mask, tb_fcnt, tb_fcell);
    e.hs  = hs;
    e.vs  = vs;
    sb.push_back(e);
    efs      = (h == 0 && v == 0) && !prev_org;
    prev_org = (h == 0 && v == 0);
    @(posedge clk);
    #1;
    hit_strobe = 1'b0;
    check("frame_start", {7'd0, frame_start}, {7'd0, efs});
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check("rgb", rgb, e.rgb);
      check("hsync_out", {7'd0, hsync_out}, {7'd0, e.hs});
      check("vsync_out", {7'd0, vsync_out}, {7'd0, e.vs});
    end
  endtask

  task automatic idle();
    step(0, 600, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic origin();
    step(0, 0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic pix(input int h, input int v);
    step(h, v, 1'b1, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic hit(input logic [3:0] hc);
    step(0, 600, 1'b0, 1'b0, 1'b1, hc);
  endtask

  // Async reset: outputs must clear without a clock edge
  task automatic do_reset();
    rst        = 1'b0;
    h_count    = 11'd244;
    v_count    = 11'd115;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    mole_up    = 9'h1FF;
    hit_strobe = 1'b1;
    hit_cell   = 4'd4;
    #5;
    check("rst_rgb", rgb, 8'h00);
    check("rst_hsync", {7'd0, hsync_out}, 8'h00);
    check("rst_vsync", {7'd0, vsync_out}, 8'h00);
    check("rst_frame_start", {7'd0, frame_start}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_rgb", rgb, 8'h00);
    check("rst_hold_frame_start", {7'd0, frame_start}, 8'h00);
    sb.delete();
    prev_org   = 1'b0;
    tb_mask    = 9'd0;
    tb_fcnt    = 0;
    tb_fcell   = 0;
    h_count    = 11'd0;
    v_count    = 11'd600;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    hit_strobe = 1'b0;
    hit_cell   = 4'd0;
    mole_up    = 9'h000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    #3;
    do_reset();

    // Coarse frame sweep with no moles latched: only grass/hole/blank allowed
    for (int v = 0; v < 525; v += 31) begin
      for (int h = 0; h < 800; h += 23) begin
        step(h, v, 1'b0, 1'b0, 1'b0, 4'd0);
      end
    end
    idle();

    // Mask latch for cell 0, including mole-square and grid edges
    mole_up = 9'h001;
    idle();
    origin();
    tb_mask = 9'h001;
    idle();
    pix(244, 115);
    pix(229, 115);
    pix(164, 115);
    pix(243, 115);
    pix(363, 115);
    pix(364, 115);
    pix(224, 100);
    pix(223, 100);

    // Mid-frame mole_up change must wait for the next frame start
    mole_up = 9'h000;
    pix(244, 115);
    idle();
    pix(244, 115);
    origin();
    tb_mask = 9'h000;
    idle();
    pix(244, 115);

    // Flash on cell 4 lasts exactly 8 frame starts
    mole_up = 9'h010;
    origin();
    tb_mask = 9'h010;
    idle();
    hit(4'd4);
    tb_fcnt  = 8;
    tb_fcell = 4;
    for (int k = 0; k < 8; k++) begin
      pix(464, 275);
      origin();
      tb_fcnt--;
      idle();
    end
    pix(464, 275);

    // Hit in the same cycle as frame_start: load wins, still 8 frames
    origin();
    hit(4'd4);
    tb_fcnt  = 8;
    tb_fcell = 4;
    for (int k = 0; k < 8; k++) begin
      pix(464, 275);
      origin();
      tb_fcnt--;
      idle();
    end
    pix(464, 275);

    // Out-of-range hit is ignored; a new hit overrides the running flash
    hit(4'd11);
    pix(464, 275);
    hit(4'd4);
    tb_fcnt  = 8;
    tb_fcell = 4;
    pix(464, 275);
    hit(4'd11);
    pix(464, 275);
    pix(244, 115);
    hit(4'd0);
    tb_fcell = 0;
    pix(464, 275);
    pix(244, 115);
    for (int k = 0; k < 8; k++) begin
      origin();
      tb_fcnt--;
      idle();
    end
    pix(244, 115);

    // Active-area borders
    pix(143, 40);
    pix(144, 40);
    pix(783, 300);
    pix(784, 300);
    pix(300, 34);
    pix(300, 514);
    pix(300, 515);

    // Sync pulses keep width and are delayed exactly 2 clk
    for (int i = 0; i < 8; i++) begin
      step(300, 200, (i >= 2 && i < 5), (i == 3), 1'b0, 4'd0);
    end
    idle();

    // Holding at origin pulses once; leaving and re-entering pulses again
    origin();
    origin();
    origin();
    idle();
    origin();
    idle();

    // Reset mid-frame: outputs clear at once, mask restarts at 0
    mole_up = 9'h001;
    origin();
    tb_mask = 9'h001;
    idle();
    pix(244, 115);
    pix(244, 115);
    check("pre_reset_rgb", rgb, C_MOLE);
    do_reset();
    mole_up = 9'h001;
    idle();
    pix(244, 115);
    origin();
    tb_mask = 9'h001;
    idle();
    pix(244, 115);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
